// File: rtl/param_tx_frame_streamer_if.sv
// Bundle of control, RAM port-2 and byte-link signals for param_tx_frame_streamer.
// The master modport is the streamer; the slave modport is the CPU/RAM/link side.
interface param_tx_frame_streamer_if #(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 11
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_chipselect;
    logic              ram_write;
    logic [31:0]       ram_readdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;
    logic [7:0]        checksum;

    modport master (
        input  start, base_addr, word_count, ram_readdata, tx_ready,
        output ram_address, ram_chipselect, ram_write, tx_data, tx_valid,
               busy, done, checksum
    );

    modport slave (
        output start, base_addr, word_count, ram_readdata, tx_ready,
        input  ram_address, ram_chipselect, ram_write, tx_data, tx_valid,
               busy, done, checksum
    );
endinterface

// File: rtl/param_tx_frame_streamer.sv
// Streams a block of 32-bit RAM words as a framed byte stream: A5, count, data, check byte.
// Define PARAM_TX_CRC8_EN to make the check byte CRC-8 (poly 0x07) instead of an additive sum.
module param_tx_frame_streamer #(
    parameter int ADDR_W    = 11,
    parameter int MAX_WORDS = 1025,
    parameter int CNT_W     = 11
) (
    input  logic                          clk,
    input  logic                          reset,
    param_tx_frame_streamer_if.master     bus
);
    localparam logic [31:0]       MAX_W32   = MAX_WORDS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, SYNC, CNT_H, CNT_L, RD_REQ, RD_WAIT, BYTE, CK
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  words_left_reg;
    logic [1:0]        byte_idx_reg;
    logic [31:0]       shift_reg;
    logic [7:0]        sum_reg;
    logic [7:0]        checksum_reg;
    logic              done_reg;

    logic              tx_valid_next;
    logic [7:0]        tx_byte;
    logic [7:0]        sum_next;
    logic              accept;
    logic [15:0]       hdr;
    logic [CNT_W-1:0]  count_clamped;
    logic [ADDR_W-1:0] base_wrapped;

    assign hdr           = 16'(count_reg);
    assign count_clamped = (32'(bus.word_count) > MAX_W32) ? CNT_W'(MAX_WORDS) : bus.word_count;
    assign base_wrapped  = ADDR_W'(32'(bus.base_addr) % MAX_W32);
    assign accept        = tx_valid_next & bus.tx_ready;

`ifdef PARAM_TX_CRC8_EN
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
    assign sum_next = crc8_step(sum_reg, tx_byte);
`else
    assign sum_next = sum_reg + tx_byte;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        tx_valid_next = 1'b0;
        tx_byte       = 8'h00;
        case (state_reg)
            IDLE: begin
                if (bus.start) state_next = SYNC;
            end
            SYNC: begin
                tx_valid_next = 1'b1;
                tx_byte       = 8'hA5;
                if (bus.tx_ready) state_next = CNT_H;
            end
            CNT_H: begin
                tx_valid_next = 1'b1;
                tx_byte       = hdr[15:8];
                if (bus.tx_ready) state_next = CNT_L;
            end
            CNT_L: begin
                tx_valid_next = 1'b1;
                tx_byte       = hdr[7:0];
                if (bus.tx_ready) state_next = (count_reg != '0) ? RD_REQ : CK;
            end
            RD_REQ:  state_next = RD_WAIT;
            RD_WAIT: state_next = BYTE;
            BYTE: begin
                tx_valid_next = 1'b1;
                tx_byte       = shift_reg[7:0];
                // words_left_reg was already decremented when this word was captured
                if (bus.tx_ready && byte_idx_reg == 2'd3)
                    state_next = (words_left_reg == '0) ? CK : RD_REQ;
            end
            CK: begin
                tx_valid_next = 1'b1;
                tx_byte       = sum_reg;
                if (bus.tx_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg       <= '0;
            count_reg      <= '0;
            words_left_reg <= '0;
            byte_idx_reg   <= '0;
            shift_reg      <= '0;
            sum_reg        <= '0;
            checksum_reg   <= '0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        addr_reg       <= base_wrapped;
                        count_reg      <= count_clamped;
                        words_left_reg <= count_clamped;
                        sum_reg        <= '0;
                    end
                end
                CNT_H, CNT_L: begin
                    if (accept) sum_reg <= sum_next;
                end
                RD_WAIT: begin
                    shift_reg      <= bus.ram_readdata;
                    byte_idx_reg   <= '0;
                    words_left_reg <= words_left_reg - 1'b1;
                    addr_reg       <= (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;
                end
                BYTE: begin
                    if (accept) begin
                        sum_reg      <= sum_next;
                        shift_reg    <= {8'h00, shift_reg[31:8]};
                        byte_idx_reg <= byte_idx_reg + 1'b1;
                    end
                end
                CK: begin
                    if (accept) begin
                        checksum_reg <= sum_reg;
                        done_reg     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_address    = addr_reg;
    assign bus.ram_chipselect = (state_reg == RD_REQ);
    assign bus.ram_write      = 1'b0;
    assign bus.tx_data        = tx_byte;
    assign bus.tx_valid       = tx_valid_next;
    assign bus.busy           = (state_reg != IDLE);
    assign bus.done           = done_reg;
    assign bus.checksum       = checksum_reg;
endmodule

// File: tb/tb_param_tx_frame_streamer.sv
// Directed bench for param_tx_frame_streamer: expected bytes are queued when a frame is
// started and popped as the link accepts them; honours PARAM_TX_CRC8_EN in its model.
module tb_param_tx_frame_streamer;
    localparam int ADDR_W = 11;
    localparam int CNT_W  = 11;
    localparam int MAXW   = 1025;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    param_tx_frame_streamer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    param_tx_frame_streamer #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    logic [31:0] mem [0:MAXW-1];
    always @(posedge clk) begin
        if (bus.ram_chipselect && !bus.ram_write && bus.ram_address < MAXW)
            bus.ram_readdata <= mem[bus.ram_address];
    end

    int          errors   = 0;
    int          checks   = 0;
    int          done_cnt = 0;
    int          frame_d0 = 0;
    logic [7:0]  exp_q[$];
    logic [10:0] addr_log[$];
    logic [7:0]  exp_ck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference for the check byte
    function automatic logic [7:0] acc(input logic [7:0] ck, input logic [7:0] b);
`ifdef PARAM_TX_CRC8_EN
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = ck[7] ^ b[i];
            ck = {ck[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return ck;
`else
        return ck + b;
`endif
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.done) done_cnt++;
            if (bus.ram_chipselect) addr_log.push_back(bus.ram_address);
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) check("unexpected_byte", {24'h0, bus.tx_data}, 32'hFFFF_FFFF);
                else                   check("byte", {24'h0, bus.tx_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic build_frame(input int base, input int count);
        int          n;
        int          a;
        logic [7:0]  ck;
        logic [15:0] h;
        logic [31:0] w;
        n  = (count > MAXW) ? MAXW : count;
        a  = base % MAXW;
        ck = 8'h00;
        h  = 16'(n);
        exp_q.push_back(8'hA5);
        exp_q.push_back(h[15:8]); ck = acc(ck, h[15:8]);
        exp_q.push_back(h[7:0]);  ck = acc(ck, h[7:0]);
        for (int i = 0; i < n; i++) begin
            w = mem[a];
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back(w[8*k +: 8]);
                ck = acc(ck, w[8*k +: 8]);
            end
            a = (a + 1) % MAXW;
        end
        exp_q.push_back(ck);
        exp_ck = ck;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle presenting the sync byte
    task automatic start_frame(input int base, input int count);
        build_frame(base, count);
        frame_d0       = done_cnt;
        bus.base_addr  = ADDR_W'(base);
        bus.word_count = CNT_W'(count);
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("latency_valid", {31'h0, bus.tx_valid}, 32'h1);
        check("latency_sync", {24'h0, bus.tx_data}, 32'hA5);
        check("busy_after_start", {31'h0, bus.busy}, 32'h1);
    endtask

    task automatic wait_frame(input int base, input int count, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", {31'h0, seen}, 32'h1);
        if (seen) begin
            check("busy_at_done", {31'h0, bus.busy}, 32'h0);
            check("checksum", {24'h0, bus.checksum}, {24'h0, exp_ck});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("done_pulses", done_cnt - frame_d0, 32'h1);
        check("bytes_left", exp_q.size(), 32'h0);
        $display("frame base=%0d count=%0d checksum=0x%02h done_pulses=%0d",
                 base, count, bus.checksum, done_cnt - frame_d0);
        exp_q.delete();
    endtask

    task automatic run_frame(input int base, input int count, input int budget);
        start_frame(base, count);
        wait_frame(base, count, budget);
    endtask

    initial begin
        int  cs_seen;
        bit  hit;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        bus.tx_ready   = 1'b1;
        for (int i = 0; i < MAXW; i++) mem[i] = 32'h0;

        // Reset state
        #1;
        check("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_checksum", {24'h0, bus.checksum}, 32'h0);
        check("rst_cs", {31'h0, bus.ram_chipselect}, 32'h0);
        check("rst_addr", {21'h0, bus.ram_address}, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single word
        mem[0] = 32'h1122_3344;
        run_frame(0, 1, 50);
`ifndef PARAM_TX_CRC8_EN
        check("single_ck_const", {24'h0, bus.checksum}, 32'hAB);
`endif

        // Empty frame, no RAM access
        addr_log.delete();
        run_frame(7, 0, 50);
        check("empty_no_cs", addr_log.size(), 32'h0);

        // Backpressure on byte 0x33
        start_frame(0, 1);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.tx_valid && bus.tx_data == 8'h33) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("bp_found_33", {31'h0, hit}, 32'h1);
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid_held", {31'h0, bus.tx_valid}, 32'h1);
            check("bp_data_held", {24'h0, bus.tx_data}, 32'h33);
        end
        bus.tx_ready = 1'b1;
        wait_frame(0, 1, 50);

        // Address wrap and base reduction
        mem[1024] = 32'h0000_00FF;
        mem[0]    = 32'h0000_0001;
        addr_log.delete();
        run_frame(1024, 2, 50);
        check("wrap_n_reads", addr_log.size(), 32'h2);
        if (addr_log.size() == 2) begin
            check("wrap_addr0", {21'h0, addr_log[0]}, 32'd1024);
            check("wrap_addr1", {21'h0, addr_log[1]}, 32'd0);
        end
`ifndef PARAM_TX_CRC8_EN
        check("wrap_ck_const", {24'h0, bus.checksum}, 32'h02);
`endif

        // Count clamp
        for (int i = 0; i < MAXW; i++) mem[i] = $urandom;
        addr_log.delete();
        run_frame(0, 2000, 8000);
        check("clamp_n_reads", addr_log.size(), 32'd1025);

        // Start while busy is ignored
        start_frame(5, 3);
        repeat (6) begin @(posedge clk); #1; end
        bus.base_addr  = 11'd100;
        bus.word_count = 11'd7;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_frame(5, 3, 100);

        // Reset during the third word read
        addr_log.delete();
        start_frame(0, 5);
        cs_seen = 0;
        hit     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.ram_chipselect) begin
                cs_seen++;
                if (cs_seen == 3) begin
                    hit = 1'b1;
                    break;
                end
            end
            @(posedge clk); #1;
        end
        check("rst_mid_reached_word3", {31'h0, hit}, 32'h1);
        frame_d0 = done_cnt;
        reset    = 1'b1;
        #1;
        check("rst_mid_valid", {31'h0, bus.tx_valid}, 32'h0);
        check("rst_mid_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_mid_cs", {31'h0, bus.ram_chipselect}, 32'h0);
        check("rst_mid_checksum", {24'h0, bus.checksum}, 32'h0);
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_no_done", done_cnt - frame_d0, 32'h0);
        run_frame(0, 5, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/param_tx_frame_streamer.md
Name: param_tx_frame_streamer

Overview:
- Reads a contiguous block of 32-bit parameter words from port 2 of the parameter TX dual-port RAM.
- Serialises the words into a framed byte stream for the downstream byte link (UART/serial TX), using a valid/ready handshake.
- The CPU fills the RAM through port 1 and then pulses start. This block is the consumer stage directly downstream of the RAM.

Parameters:
- ADDR_W, 11, RAM word-address width.
- MAX_WORDS, 1025, RAM depth. Addresses wrap modulo MAX_WORDS.
- CNT_W, 11, width of word_count.

Ports:
- clk  in  1  system clock; every register is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to send a frame. Ignored while busy=1.
- base_addr  in  ADDR_W  first RAM word address, sampled on an accepted start.
- word_count  in  CNT_W  number of words to send, sampled on an accepted start.
- ram_address  out  ADDR_W  port-2 address to the RAM.
- ram_chipselect  out  1  port-2 chipselect. High only in RD_REQ.
- ram_write  out  1  port-2 write. Tied 0.
- ram_readdata  in  32  port-2 read data. Valid in the cycle after ram_address is registered by the RAM.
- tx_data  out  8  byte to the link.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  link accepts the byte when tx_valid & tx_ready.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse after the last byte is accepted.
- checksum  out  8  checksum of the last completed frame. Held until the next frame completes.

Behaviour:
- Reset (async, active-high) state, all forced immediately:
  - State IDLE.
  - tx_valid=0, tx_data=0, busy=0, done=0, checksum=0.
  - ram_address=0, ram_chipselect=0.
- Frame format:
  - 0xA5 sync byte.
  - CNT_H = {5'b0, count[10:8]}, then CNT_L = count[7:0].
  - For each word: 4 data bytes, little-endian (bits 7:0 first).
  - CK byte = sum mod 256 of every byte after the sync byte.
- Count clamp: if word_count > MAX_WORDS, count = MAX_WORDS. The header carries the clamped value.
- Accepted start: start=1 in IDLE. Latches base and count, clears the running sum, sets busy next cycle.
- States:
  - IDLE -> SYNC -> CNT_H -> CNT_L.
  - CNT_L -> RD_REQ if count>0, else -> CK.
  - RD_REQ -> RD_WAIT -> BYTE (index 0..3).
  - BYTE (index 3) -> RD_REQ if words remain, else -> CK.
  - CK -> IDLE.
- Byte states:
  - SYNC, CNT_H, CNT_L, BYTE and CK each present one byte with tx_valid=1.
  - A byte state advances only on the cycle where tx_valid & tx_ready.
  - tx_data is held stable while tx_valid=1 and tx_ready=0.
- Read timing:
  - RD_REQ drives ram_address = current address with ram_chipselect=1.
  - RD_WAIT captures ram_readdata into a 32-bit shift register at its closing clock edge.
  - tx_valid=0 in RD_REQ and RD_WAIT.
- Latency: start at edge N gives tx_valid=1 with 0xA5 after edge N+1. Each word adds 2 bubble cycles before its first byte.
- Address increment: after each word is captured. MAX_WORDS-1 wraps to 0. A base_addr >= MAX_WORDS is reduced modulo MAX_WORDS.
- Checksum: the running sum updates on each accepted non-sync byte, 8-bit wrap. The CK byte presents the sum excluding itself.
- Completion: on acceptance of CK, the checksum output is loaded, done pulses for 1 cycle, busy=0 and the state returns to IDLE. A new start is accepted in the cycle after done.
- start while busy: ignored; no effect on the frame in progress.
- Reset mid-frame: the frame is abandoned. No done pulse, and checksum keeps its reset value of 0.

Optional Feature:
- Macro: PARAM_TX_CRC8_EN.
- Defined: the CK byte and the checksum output are CRC-8, polynomial 0x07, init 0x00, MSB-first, over the same bytes (all bytes after sync). The CRC updates one byte per accepted byte, computed combinationally within the cycle.
- Undefined: 8-bit additive sum as described in Behaviour.
- Frame length and timing are identical in both builds.

Test Plan:
- Single word: RAM[0]=0x11223344, base=0, count=1, tx_ready=1 -> bytes A5 00 01 44 33 22 11 AB. checksum=0xAB; done pulses once; busy falls with done.
- Empty frame: count=0 -> bytes A5 00 00 00. No RAM access: ram_chipselect stays 0. done pulses.
- Backpressure: drop tx_ready for 5 cycles while byte 0x33 is presented -> tx_data stays 0x33 and tx_valid stays 1. The stream then resumes with no lost or duplicated byte.
- Wrap and clamp:
  - base=1024, count=2, RAM[1024]=0x000000FF, RAM[0]=0x00000001 -> ram_address sequence 1024 then 0; checksum=0x02+0xFF+0x01=0x02.
  - count=2000 -> header 04 01 and 1025 words sent.
- Start while busy: pulse start mid-frame with a different base -> ignored; the current frame completes unchanged with exactly one done pulse.
- Reset mid-frame: assert reset during word 3 -> tx_valid, busy and ram_chipselect drop without waiting for a clock edge. No done pulse. A fresh start then yields a correct full frame.
- CRC build (PARAM_TX_CRC8_EN): single-word case above -> CK equals CRC-8/0x07 of 00 01 44 33 22 11, checked against a bench reference model.
